// File: rtl/rfphoenix_vec_opcollect_pkg.sv
// Shared types for the vector operand-collection stage.
package rfPhoenixPkg;

  localparam int NLANES = 16;
  localparam int NREGS  = 64;
  localparam int RW     = 6;
  localparam int VW     = 32;
  localparam int IW     = 32;

  typedef logic [IW-1:0]              Instruction;
  typedef logic [VW-1:0]              Value;
  typedef logic [NLANES-1:0][VW-1:0]  VecValue;
  typedef logic [RW-1:0]              Regspec;

  // Everything the vector ALU receives with one handshake.
  typedef struct packed {
    Instruction ir;
    VecValue    a;
    VecValue    b;
    VecValue    c;
    VecValue    t;
    logic       ta;
    logic       tb;
    logic       tt;
    Value       imm;
  } OpBundle;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDAB,
    ST_CAPAB,
    ST_CAPCT,
    ST_OUT
  } oc_state_e;

  // A writeback is forwarded into an operand only if the operand is live
  // and names a real register (register 0 is hard-wired to zero).
  function automatic logic wb_hit(input logic   hit_v,
                                  input Regspec hit_reg,
                                  input Regspec spec,
                                  input logic   need);
    return hit_v && (hit_reg == spec) && (spec != '0) && need;
  endfunction

endpackage

// File: rtl/rfphoenix_vec_opcollect_lanemerge.sv
// Lane-wise merge of writeback data into a vector operand.
module rfphoenix_vec_lanemerge
  import rfPhoenixPkg::*;
(
  input  VecValue                 old_val,
  input  VecValue                 wb_data,
  input  logic [NLANES-1:0]       wb_mask,
  output VecValue                 merged
);

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      assign merged[gi] = wb_mask[gi] ? wb_data[gi] : old_val[gi];
    end
  endgenerate

endmodule

// File: rtl/rfphoenix_vec_opcollect.sv
// Collects up to four vector operands over one or two register-file read
// cycles, forwards in-flight writebacks, and hands a registered bundle to
// the vector ALU.
module rfphoenix_vec_opcollect
  import rfPhoenixPkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_v,
  output logic              issue_rdy,
  input  Instruction        issue_ir,
  input  Regspec            issue_ra,
  input  Regspec            issue_rb,
  input  Regspec            issue_rc,
  input  Regspec            issue_rt,
  input  logic [3:0]        issue_need,
  input  logic              issue_ta,
  input  logic              issue_tb,
  input  logic              issue_tt,
  input  Value              issue_imm,
  output Regspec            rf_addr0,
  output Regspec            rf_addr1,
  input  VecValue           rf_data0,
  input  VecValue           rf_data1,
  input  logic              wb_v,
  input  Regspec            wb_reg,
  input  logic [NLANES-1:0] wb_mask,
  input  VecValue           wb_data,
  output logic              op_v,
  input  logic              op_rdy,
  output Instruction        op_ir,
  output VecValue           op_a,
  output VecValue           op_b,
  output VecValue           op_c,
  output VecValue           op_t,
  output logic              op_ta,
  output logic              op_tb,
  output logic              op_tt,
  output Value              op_imm
);

  oc_state_e  state_q, state_d;
  Instruction ir_q, ir_d;
  Regspec     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d, rt_q, rt_d;
  logic [3:0] need_q, need_d;
  logic       ta_q, ta_d, tb_q, tb_d, tt_q, tt_d;
  Value       imm_q, imm_d;
  OpBundle    bundle_q, bundle_d;

  logic       accept;

  // Per-operand view, index 0..3 = a, b, c, t.
  Regspec     spec  [4];
  VecValue    held  [4];
  VecValue    rfd   [2];
  VecValue    base  [4];
  VecValue    mrg   [4];
  VecValue    sel   [4];
  logic [NLANES-1:0] msk [4];

  assign spec[0] = ra_q;
  assign spec[1] = rb_q;
  assign spec[2] = rc_q;
  assign spec[3] = rt_q;
  assign held[0] = bundle_q.a;
  assign held[1] = bundle_q.b;
  assign held[2] = bundle_q.c;
  assign held[3] = bundle_q.t;
  assign rfd[0]  = rf_data0;
  assign rfd[1]  = rf_data1;

  // In its capture cycle an operand starts from fresh RF data; afterwards
  // from its held value. Either way a matching writeback overrides lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_opnd
      localparam oc_state_e CAP_ST = (gi < 2) ? ST_CAPAB : ST_CAPCT;
      assign base[gi] = (state_q == CAP_ST) ? rfd[gi % 2] : held[gi];
      assign msk[gi]  = wb_mask & {NLANES{wb_hit(wb_v, wb_reg, spec[gi], need_q[gi])}};
      rfphoenix_vec_lanemerge u_merge (
        .old_val (base[gi]),
        .wb_data (wb_data),
        .wb_mask (msk[gi]),
        .merged  (mrg[gi])
      );
      assign sel[gi] = (need_q[gi] && (spec[gi] != '0)) ? mrg[gi] : '0;
    end
  endgenerate

  assign issue_rdy = !flush && !rst &&
                     ((state_q == ST_IDLE) || ((state_q == ST_OUT) && op_rdy));
  assign accept    = issue_v && issue_rdy;

  assign op_v   = (state_q == ST_OUT);
  assign op_ir  = bundle_q.ir;
  assign op_a   = bundle_q.a;
  assign op_b   = bundle_q.b;
  assign op_c   = bundle_q.c;
  assign op_t   = bundle_q.t;
  assign op_ta  = bundle_q.ta;
  assign op_tb  = bundle_q.tb;
  assign op_tt  = bundle_q.tt;
  assign op_imm = bundle_q.imm;

  // Next-state, RF address and bundle capture/update logic.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    rt_d     = rt_q;
    need_d   = need_q;
    ta_d     = ta_q;
    tb_d     = tb_q;
    tt_d     = tt_q;
    imm_d    = imm_q;
    bundle_d = bundle_q;
    rf_addr0 = '0;
    rf_addr1 = '0;

    if (accept) begin
      ir_d   = issue_ir;
      ra_d   = issue_ra;
      rb_d   = issue_rb;
      rc_d   = issue_rc;
      rt_d   = issue_rt;
      need_d = issue_need;
      ta_d   = issue_ta;
      tb_d   = issue_tb;
      tt_d   = issue_tt;
      imm_d  = issue_imm;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RDAB;
      end
      ST_RDAB: begin
        rf_addr0 = ra_q;
        rf_addr1 = rb_q;
        state_d  = ST_CAPAB;
      end
      ST_CAPAB: begin
        bundle_d.ir  = ir_q;
        bundle_d.ta  = ta_q;
        bundle_d.tb  = tb_q;
        bundle_d.tt  = tt_q;
        bundle_d.imm = imm_q;
        bundle_d.a   = sel[0];
        bundle_d.b   = sel[1];
        if (need_q[2] || need_q[3]) begin
          rf_addr0 = rc_q;
          rf_addr1 = rt_q;
          state_d  = ST_CAPCT;
        end else begin
          bundle_d.c = '0;
          bundle_d.t = '0;
          state_d    = ST_OUT;
        end
      end
      ST_CAPCT: begin
        bundle_d.a = sel[0];
        bundle_d.b = sel[1];
        bundle_d.c = sel[2];
        bundle_d.t = sel[3];
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (op_rdy) begin
          state_d = accept ? ST_RDAB : ST_IDLE;
        end else begin
          bundle_d.a = sel[0];
          bundle_d.b = sel[1];
          bundle_d.c = sel[2];
          bundle_d.t = sel[3];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush abandons the instruction; the bundle is simply left alone.
    if (flush) begin
      state_d  = ST_IDLE;
      bundle_d = bundle_q;
    end
  end

  // State, latched issue fields and the outgoing bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      rt_q     <= '0;
      need_q   <= '0;
      ta_q     <= 1'b0;
      tb_q     <= 1'b0;
      tt_q     <= 1'b0;
      imm_q    <= '0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      rt_q     <= rt_d;
      need_q   <= need_d;
      ta_q     <= ta_d;
      tb_q     <= tb_d;
      tt_q     <= tt_d;
      imm_q    <= imm_d;
      bundle_q <= bundle_d;
    end
  end

endmodule

// File: tb/tb_rfphoenix_vec_opcollect.sv
// Self-checking bench for the vector operand-collection stage.
module tb_rfphoenix_vec_opcollect;
  import rfPhoenixPkg::*;

  logic              clk = 1'b0;
  logic              rst, flush, issue_v, issue_rdy;
  Instruction        issue_ir;
  Regspec            issue_ra, issue_rb, issue_rc, issue_rt;
  logic [3:0]        issue_need;
  logic              issue_ta, issue_tb, issue_tt;
  Value              issue_imm;
  Regspec            rf_addr0, rf_addr1;
  VecValue           rf_data0, rf_data1;
  logic              wb_v;
  Regspec            wb_reg;
  logic [NLANES-1:0] wb_mask;
  VecValue           wb_data;
  logic              op_v, op_rdy;
  Instruction        op_ir;
  VecValue           op_a, op_b, op_c, op_t;
  logic              op_ta, op_tb, op_tt;
  Value              op_imm;

  always #5 clk = ~clk;

  rfphoenix_vec_opcollect dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_v(issue_v), .issue_rdy(issue_rdy), .issue_ir(issue_ir),
    .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_rc(issue_rc), .issue_rt(issue_rt),
    .issue_need(issue_need), .issue_ta(issue_ta), .issue_tb(issue_tb), .issue_tt(issue_tt),
    .issue_imm(issue_imm),
    .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_data0(rf_data0), .rf_data1(rf_data1),
    .wb_v(wb_v), .wb_reg(wb_reg), .wb_mask(wb_mask), .wb_data(wb_data),
    .op_v(op_v), .op_rdy(op_rdy), .op_ir(op_ir),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_t(op_t),
    .op_ta(op_ta), .op_tb(op_tb), .op_tt(op_tt), .op_imm(op_imm)
  );

  // Register file: data appears one cycle after the address; writebacks
  // land at the clock edge, so a read sees every write of earlier cycles.
  VecValue mem [NREGS];
  Regspec  raddr0_q, raddr1_q;
  always @(posedge clk) begin
    raddr0_q <= rf_addr0;
    raddr1_q <= rf_addr1;
    if (wb_v)
      for (int l = 0; l < NLANES; l++)
        if (wb_mask[l]) mem[wb_reg][l] <= wb_data[l];
  end
  assign rf_data0 = mem[raddr0_q];
  assign rf_data1 = mem[raddr1_q];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one instruction in flight; its bundle becomes visible
  // 3 or 4 cycles after acceptance, and every visible operand must equal
  // the architectural register contents (0 if unneeded or register 0).
  logic       pend = 1'b0;
  int         pend_ready = 0;
  int         cyc = 0;
  Instruction p_ir;
  Regspec     p_ra, p_rb, p_rc, p_rt;
  logic [3:0] p_need;
  logic       p_ta, p_tb, p_tt;
  Value       p_imm;

  function automatic VecValue exp_op(input Regspec s, input logic n);
    return (n && s != '0) ? mem[s] : '0;
  endfunction

  function automatic VecValue rnd_vec();
    VecValue v;
    for (int l = 0; l < NLANES; l++) v[l] = $urandom;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    logic vexp, xfer, acc;
    @(negedge clk);
    vexp = pend && (cyc >= pend_ready);
    chk("op_v", op_v, vexp);
    chk("issue_rdy", issue_rdy, !flush && (!pend || (vexp && op_rdy)));
    if (vexp) begin
      chk("bundle_ir", op_ir, p_ir);
      chk("bundle_a", op_a, exp_op(p_ra, p_need[0]));
      chk("bundle_b", op_b, exp_op(p_rb, p_need[1]));
      chk("bundle_c", op_c, exp_op(p_rc, p_need[2]));
      chk("bundle_t", op_t, exp_op(p_rt, p_need[3]));
      chk("bundle_flags", {op_ta, op_tb, op_tt}, {p_ta, p_tb, p_tt});
      chk("bundle_imm", op_imm, p_imm);
    end
    xfer = vexp && op_rdy;
    acc  = issue_v && !flush && (!pend || xfer);
    if (flush || xfer) pend = 1'b0;
    if (acc) begin
      pend       = 1'b1;
      pend_ready = cyc + ((issue_need[2] || issue_need[3]) ? 4 : 3);
      p_ir = issue_ir;  p_ra = issue_ra;  p_rb = issue_rb;
      p_rc = issue_rc;  p_rt = issue_rt;  p_need = issue_need;
      p_ta = issue_ta;  p_tb = issue_tb;  p_tt = issue_tt;  p_imm = issue_imm;
    end
    cyc++;
  endtask

  task automatic set_issue(input Regspec a, input Regspec b, input Regspec c,
                           input Regspec t, input logic [3:0] n);
    issue_v    = 1'b1;
    issue_ir   = $urandom;
    issue_ra   = a;  issue_rb = b;  issue_rc = c;  issue_rt = t;
    issue_need = n;
    issue_ta   = 1'($urandom);
    issue_tb   = 1'($urandom);
    issue_tt   = 1'($urandom);
    issue_imm  = $urandom;
  endtask

  VecValue v11, v22, v33, v44, vaa, vbb, m1, m2;

  initial begin
    v11 = {NLANES{32'h11111111}};
    v22 = {NLANES{32'h22222222}};
    v33 = {NLANES{32'h33333333}};
    v44 = {NLANES{32'h44444444}};
    vaa = {NLANES{32'hAAAAAAAA}};
    vbb = {NLANES{32'hBBBBBBBB}};
    for (int l = 0; l < NLANES; l++) begin
      m1[l] = (l < 8) ? 32'hAAAAAAAA : 32'h11111111;
      m2[l] = (l < 8) ? 32'hAAAAAAAA : 32'hBBBBBBBB;
    end

    rst = 1'b1; flush = 1'b0; issue_v = 1'b0; op_rdy = 1'b1;
    issue_ir = '0; issue_ra = '0; issue_rb = '0; issue_rc = '0; issue_rt = '0;
    issue_need = '0; issue_ta = 1'b0; issue_tb = 1'b0; issue_tt = 1'b0; issue_imm = '0;
    wb_v = 1'b0; wb_reg = '0; wb_mask = '0; wb_data = '0;

    // Reset state
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_op_v", op_v, 1'b0);
    chk("rst_op_a", op_a, '0);
    chk("rst_op_ir", op_ir, '0);
    chk("rst_rf_addr0", rf_addr0, '0);
    next_cycle(); rst = 1'b0;
    observe();
    chk("rst_rdy", issue_rdy, 1'b1);
    chk("rst_op_imm", op_imm, '0);

    // Fill the register file through the writeback port
    for (int r = 0; r < NREGS; r++) begin
      next_cycle();
      wb_v = 1'b1; wb_reg = Regspec'(r); wb_mask = '1;
      wb_data = rnd_vec();
      wb_data[0][0] = 1'b1;
      if (r == 3) wb_data = v11;
      if (r == 5) wb_data = v22;
      if (r == 7) wb_data = v33;
      if (r == 9) wb_data = v44;
      observe();
    end

    // 1: a/b only, three-cycle latency
    next_cycle(); wb_v = 1'b0; set_issue(3, 5, 7, 9, 4'b0011); observe();
    next_cycle(); issue_v = 1'b0; observe();
    chk("t1_addr0", rf_addr0, 6'd3);
    chk("t1_addr1", rf_addr1, 6'd5);
    next_cycle(); observe();
    chk("t1_addr0_cap", rf_addr0, '0);
    next_cycle(); observe();
    chk("t1_op_v", op_v, 1'b1);
    chk("t1_op_a", op_a, v11);
    chk("t1_op_b", op_b, v22);
    chk("t1_op_c", op_c, '0);
    chk("t1_op_t", op_t, '0);
    next_cycle(); observe();

    // 2: all four operands, second read cycle
    next_cycle(); set_issue(3, 5, 7, 9, 4'b1111); observe();
    next_cycle(); issue_v = 1'b0; observe();
    next_cycle(); observe();
    chk("t2_addr0", rf_addr0, 6'd7);
    chk("t2_addr1", rf_addr1, 6'd9);
    next_cycle(); observe();
    chk("t2_early_v", op_v, 1'b0);
    next_cycle(); observe();
    chk("t2_op_c", op_c, v33);
    chk("t2_op_t", op_t, v44);
    next_cycle(); observe();

    // 3: writeback in CAPAB, then during an OUT stall
    next_cycle(); set_issue(3, 5, 0, 0, 4'b0011); observe();
    next_cycle(); issue_v = 1'b0; observe();
    next_cycle(); wb_v = 1'b1; wb_reg = 3; wb_mask = 16'h00FF; wb_data = vaa; op_rdy = 1'b0; observe();
    next_cycle(); wb_v = 1'b0; observe();
    chk("t3_cap_merge", op_a, m1);
    next_cycle(); wb_v = 1'b1; wb_mask = 16'hFF00; wb_data = vbb; observe();
    next_cycle(); wb_v = 1'b0; observe();
    chk("t3_stall_merge", op_a, m2);

    // 4: long stall with an issue waiting, then back-to-back accept
    for (int i = 0; i < 5; i++) begin
      next_cycle(); set_issue(5, 0, 0, 0, 4'b0001); observe();
      chk("t4_hold_a", op_a, m2);
      chk("t4_rdy_low", issue_rdy, 1'b0);
    end
    next_cycle(); op_rdy = 1'b1; observe();
    chk("t4_b2b_accept", issue_rdy, 1'b1);
    next_cycle(); issue_v = 1'b0; observe();
    next_cycle(); observe();
    next_cycle(); observe();
    chk("t4_b2b_v", op_v, 1'b1);
    chk("t4_b2b_a", op_a, v22);
    next_cycle(); observe();

    // 5: register 0 reads as zero even with RF data and a writeback to it
    next_cycle(); set_issue(0, 0, 0, 0, 4'b0001); observe();
    next_cycle(); issue_v = 1'b0; observe();
    next_cycle(); wb_v = 1'b1; wb_reg = 0; wb_mask = '1; wb_data = vaa; observe();
    next_cycle(); wb_v = 1'b0; observe();
    chk("t5_zero_a", op_a, '0);
    next_cycle(); observe();

    // 6: flush in CAPAB blocks a concurrent issue; next cycle issues normally
    next_cycle(); set_issue(3, 5, 0, 0, 4'b0011); observe();
    next_cycle(); issue_v = 1'b0; observe();
    next_cycle(); flush = 1'b1; set_issue(7, 9, 0, 0, 4'b0011); observe();
    chk("t6_flush_rdy", issue_rdy, 1'b0);
    next_cycle(); flush = 1'b0; set_issue(7, 9, 0, 0, 4'b0011); observe();
    chk("t6_flush_op_v", op_v, 1'b0);
    next_cycle(); issue_v = 1'b0; observe();
    next_cycle(); observe();
    next_cycle(); observe();
    chk("t6_after_v", op_v, 1'b1);
    chk("t6_after_a", op_a, v33);

    // Randomised traffic over a small register window to force bypass hits
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      issue_v = 1'b0;
      if ($urandom_range(0, 1) == 1)
        set_issue(Regspec'($urandom_range(0, 7)), Regspec'($urandom_range(0, 7)),
                  Regspec'($urandom_range(0, 7)), Regspec'($urandom_range(0, 7)),
                  4'($urandom));
      wb_v    = ($urandom_range(0, 1) == 1);
      wb_reg  = Regspec'($urandom_range(0, 7));
      wb_mask = 16'($urandom);
      wb_data = rnd_vec();
      op_rdy  = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 23) == 0);
      observe();
    end
    next_cycle(); issue_v = 1'b0; wb_v = 1'b0; flush = 1'b0; op_rdy = 1'b1;
    observe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
